memory_bus_arbiter: RTL

Two-master arbiter sharing the single external memory bus (BusCycle/BusStrobe/Acknowledge/Stall handshake) between the instruction cache (master 0) and the data-side load/store port (master 1). Ownership is granted per bus cycle (held for as long as the owner keeps its Cycle high, e.g. a full 8-beat line refill), with round-robin tie-breaking. A watchdog aborts cycles that never receive an Acknowledge.

---
 rtl/memory_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-master round-robin arbiter for the shared external memory bus.
// Ownership is held per bus cycle; a watchdog aborts unacknowledged cycles.
module memory_bus_arbiter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        M0Cycle,
    input  logic        M0Strobe,
    input  logic        M0ReadWrite,
    input  logic [31:0] M0Address,
    input  logic [31:0] M0DataOut,
    output logic        M0Acknowledge,
    output logic        M0Stall,
    output logic [31:0] M0DataIn,
    output logic        M0Error,
    input  logic        M1Cycle,
    input  logic        M1Strobe,
    input  logic        M1ReadWrite,
    input  logic [31:0] M1Address,
    input  logic [31:0] M1DataOut,
    output logic        M1Acknowledge,
    output logic        M1Stall,
    output logic [31:0] M1DataIn,
    output logic        M1Error,
    output logic        BusCycle,
    output logic        BusStrobe,
    output logic        BusReadWrite,
    output logic [31:0] MemoryAddress,
    output logic [31:0] MemoryDataOut,
    input  logic        BusAcknowledge,
    input  logic        BusStall,
    input  logic [31:0] MemoryDataIn,
    output logic [1:0]  Owner
);

    localparam int unsigned CW =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TimeoutCycles);
    localparam bit WDOG_ON = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic          lock0_q, lock0_d;
    logic          lock1_q, lock1_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic own_cyc;
    logic timeout;
    logic elig0;
    logic elig1;

    assign own_cyc = ((owner_q == OWN_M0) && M0Cycle)
                  || ((owner_q == OWN_M1) && M1Cycle);
    assign timeout = WDOG_ON && (owner_q != OWN_NONE)
                  && (cnt_q == TMAX);
    assign elig0 = M0Cycle && !lock0_q;
    assign elig1 = M1Cycle && !lock1_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            lock0_q <= 1'b0;
            lock1_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            lock0_q <= lock0_d;
            lock1_q <= lock1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        lock0_d = lock0_q && M0Cycle;
        lock1_d = lock1_q && M1Cycle;
        cnt_d   = cnt_q;
        if (timeout) begin
            owner_d = OWN_NONE;
            cnt_d   = '0;
            if (owner_q == OWN_M0) begin
                lock0_d = 1'b1;
            end else begin
                lock1_d = 1'b1;
            end
        end else begin
            // Re-arbitrate whenever the bus is free or the owner let go.
            if (!own_cyc) begin
                if (elig0 && elig1) begin
                    owner_d = last_q ? OWN_M0 : OWN_M1;
                    last_d  = ~last_q;
                end else if (elig0) begin
                    owner_d = OWN_M0;
                    last_d  = 1'b0;
                end else if (elig1) begin
                    owner_d = OWN_M1;
                    last_d  = 1'b1;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            if ((owner_d != owner_q) || BusAcknowledge) begin
                cnt_d = '0;
            end else if (WDOG_ON && own_cyc && (cnt_q != TMAX)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        BusCycle      = 1'b0;
        BusStrobe     = 1'b0;
        BusReadWrite  = 1'b0;
        MemoryAddress = '0;
        MemoryDataOut = '0;
        M0Acknowledge = 1'b0;
        M1Acknowledge = 1'b0;
        M0Stall       = 1'b1;
        M1Stall       = 1'b1;
        M0DataIn      = '0;
        M1DataIn      = '0;
        M0Error       = 1'b0;
        M1Error       = 1'b0;
        Owner         = owner_q;
        unique case (owner_q)
            OWN_M0: begin
                BusCycle      = M0Cycle && !timeout;
                BusStrobe     = M0Strobe && !timeout;
                BusReadWrite  = M0ReadWrite;
                MemoryAddress = M0Address;
                MemoryDataOut = M0DataOut;
                M0Acknowledge = BusAcknowledge;
                M0Stall       = BusStall;
                M0DataIn      = MemoryDataIn;
                M0Error       = timeout;
            end
            OWN_M1: begin
                BusCycle      = M1Cycle && !timeout;
                BusStrobe     = M1Strobe && !timeout;
                BusReadWrite  = M1ReadWrite;
                MemoryAddress = M1Address;
                MemoryDataOut = M1DataOut;
                M1Acknowledge = BusAcknowledge;
                M1Stall       = BusStall;
                M1DataIn      = MemoryDataIn;
                M1Error       = timeout;
            end
            default: begin
            end
        endcase
    end

endmodule
